// File: rtl/counter_pkg.sv
// Shared types and helpers for load_step_counter.
//   state_t   : run/done state encoding (IDLE, RUN, DONE)
//   all_ones  : value with the low w bits set, used to size saturation limits
package counter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Maximum unsigned value representable in w bits (w up to 64).
  function automatic logic [63:0] all_ones(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Enable prescaler: step_c fires on the enabled cycle that completes
// PRESCALE enabled cycles.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   en_i         : count this cycle
//   clr_i        : restart the prescale window (wins over en_i)
//   step_c       : combinational step strobe from the registered count and en_i
module step_prescaler #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PS_W     = $clog2(PRESCALE + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic step_c
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  assign step_c = en_i && (ps_q == PS_LAST);

  // Next prescale count: clear, wrap on step, or advance while enabled.
  always_comb begin
    ps_d = ps_q;
    if (clr_i) begin
      ps_d = '0;
    end else if (en_i) begin
      ps_d = step_c ? '0 : PS_W'(ps_q + PS_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/load_step_counter.sv
// Loadable saturating up/down counter with step prescaler and run/done FSM.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   in, latch    : load value and load strobe (load wins over stepping)
//   dec, inc     : count-down / count-up enables; both or neither = hold
//   count, zero  : registered count and its ==0 flag
//   expired      : one-cycle pulse on the down-step that reaches the end
//   busy         : state is RUN
// Optional build macro LOAD_STEP_COUNTER_AUTO_RELOAD_EN: a down-step from 1
// while running reloads the last latched value instead of stopping at 0.
module load_step_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PS_W     = $clog2(PRESCALE + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             latch,
  input  logic             dec,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             expired,
  output logic             busy
);

  import counter_pkg::*;

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic             expired_q, expired_d;
  logic             zero_q;
  logic             busy_q;
  logic             step_c;

  // Exactly one direction enable advances the prescaler.
  step_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .en_i   (dec ^ inc),
    .clr_i  (latch),
    .step_c (step_c)
  );

`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  // Reload value tracks the most recent latch.
  always_comb begin
    reload_d = latch ? in : reload_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // Next count / state / pulse.
  always_comb begin
    count_d   = count_q;
    state_d   = state_q;
    expired_d = 1'b0;
    if (latch) begin
      count_d = in;
      state_d = (in != '0) ? RUN : DONE;
    end else if (step_c) begin
      if (dec) begin
        if (count_q > CNT_ONE) begin
          count_d = WIDTH'(count_q - CNT_ONE);
        end else if (count_q == CNT_ONE) begin
          expired_d = 1'b1;
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
          if ((state_q == RUN) && (reload_q != '0)) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
`else
          count_d = '0;
          state_d = DONE;
`endif
        end
      end else if (count_q != CNT_MAX) begin
        count_d = WIDTH'(count_q + CNT_ONE);
        state_d = RUN;
      end
    end
  end

  // Flags are derived from next-state so they register alongside count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      state_q   <= IDLE;
      expired_q <= 1'b0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      state_q   <= state_d;
      expired_q <= expired_d;
      zero_q    <= (count_d == '0);
      busy_q    <= (state_d == RUN);
    end
  end

  assign count   = count_q;
  assign zero    = zero_q;
  assign expired = expired_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_load_step_counter.sv
// Bench for load_step_counter: two instances (PRESCALE=1 and PRESCALE=3)
// share one directed stimulus stream; a cycle model checks both every cycle
// and literal expectations pin key points of the sequence.
module tb_load_step_counter;

  logic       clock = 1'b0;
  logic       reset, latch, dec, inc;
  logic [3:0] din;
  logic [3:0] count1, count3;
  logic       zero1, zero3, exp1, exp3, busy1, busy3;

  always #5 clock = ~clock;

  load_step_counter #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
    .clock(clock), .reset(reset), .in(din), .latch(latch), .dec(dec), .inc(inc),
    .count(count1), .zero(zero1), .expired(exp1), .busy(busy1)
  );

  load_step_counter #(.WIDTH(4), .PRESCALE(3)) u_dut3 (
    .clock(clock), .reset(reset), .in(din), .latch(latch), .dec(dec), .inc(inc),
    .count(count3), .zero(zero3), .expired(exp3), .busy(busy3)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state per instance: index 0 -> PRESCALE 1, index 1 -> PRESCALE 3.
  // m_st: 0 idle, 1 running, 2 done.
  int m_pre [2] = '{1, 3};
  int m_cnt [2];
  int m_rel [2];
  int m_ps  [2];
  int m_st  [2];
  int m_exp [2];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input int i);
    if (reset) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_ps[i] = 0; m_st[i] = 0; m_exp[i] = 0;
    end else if (latch) begin
      m_cnt[i] = int'(din);
      m_rel[i] = int'(din);
      m_ps[i]  = 0;
      m_st[i]  = (din != 0) ? 1 : 2;
      m_exp[i] = 0;
    end else begin
      m_exp[i] = 0;
      if (dec != inc) begin
        if (m_ps[i] == m_pre[i] - 1) begin
          m_ps[i] = 0;
          if (dec) begin
            if (m_cnt[i] > 1) begin
              m_cnt[i] = m_cnt[i] - 1;
            end else if (m_cnt[i] == 1) begin
              m_exp[i] = 1;
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
              if (m_st[i] == 1 && m_rel[i] != 0) begin
                m_cnt[i] = m_rel[i];
              end else begin
                m_cnt[i] = 0; m_st[i] = 2;
              end
`else
              m_cnt[i] = 0; m_st[i] = 2;
`endif
            end
          end else if (m_cnt[i] < 15) begin
            m_cnt[i] = m_cnt[i] + 1;
            m_st[i]  = 1;
          end
        end else begin
          m_ps[i] = m_ps[i] + 1;
        end
      end
    end
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("p1_count",   int'(count1), m_cnt[0]);
      chk("p1_zero",    int'(zero1),  (m_cnt[0] == 0) ? 1 : 0);
      chk("p1_expired", int'(exp1),   m_exp[0]);
      chk("p1_busy",    int'(busy1),  (m_st[0] == 1) ? 1 : 0);
      chk("p3_count",   int'(count3), m_cnt[1]);
      chk("p3_zero",    int'(zero3),  (m_cnt[1] == 0) ? 1 : 0);
      chk("p3_expired", int'(exp3),   m_exp[1]);
      chk("p3_busy",    int'(busy3),  (m_st[1] == 1) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit d, input bit i, input int v);
    reset = r; latch = l; dec = d; inc = i; din = 4'(v);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    chk("rst_count", int'(count1), 0);
    chk("rst_zero", int'(zero1), 1);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_expired", int'(exp1), 0);

    // Latch 15, then continuous dec on the PRESCALE=1 instance.
    drive(0, 0, 0, 0, 0);  cyc(1);
    drive(0, 1, 0, 0, 15); cyc(1);
    chk("latch15_count", int'(count1), 15);
    chk("latch15_busy", int'(busy1), 1);
    chk("latch15_expired", int'(exp1), 0);
    drive(0, 0, 0, 0, 0);  cyc(1);
    drive(0, 0, 1, 0, 0);  cyc(14);
    chk("dec14_count", int'(count1), 1);
    chk("dec14_expired", int'(exp1), 0);
    cyc(1);
    chk("dec15_expired", int'(exp1), 1);
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
    chk("dec15_count", int'(count1), 15);
    chk("dec15_zero", int'(zero1), 0);
    chk("dec15_busy", int'(busy1), 1);
`else
    chk("dec15_count", int'(count1), 0);
    chk("dec15_zero", int'(zero1), 1);
    chk("dec15_busy", int'(busy1), 0);
`endif
    cyc(1);
    chk("dec16_expired", int'(exp1), 0);
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
    chk("dec16_count", int'(count1), 14);
`else
    chk("dec16_count", int'(count1), 0);
`endif

    // PRESCALE=3: latch 5, 15 dec cycles with a 2-cycle gap.
    drive(0, 1, 0, 0, 5); cyc(1);
    drive(0, 0, 1, 0, 0); cyc(7);
    drive(0, 0, 0, 0, 0); cyc(2);
    drive(0, 0, 1, 0, 0); cyc(7);
    chk("p3_dec14_count", int'(count3), 1);
    chk("p3_dec14_expired", int'(exp3), 0);
    cyc(1);
    chk("p3_dec15_expired", int'(exp3), 1);
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
    chk("p3_dec15_count", int'(count3), 5);
`else
    chk("p3_dec15_zero", int'(zero3), 1);
`endif
    drive(0, 0, 0, 0, 0); cyc(1);
    chk("p3_after_expired", int'(exp3), 0);

    // Up-count saturation, then both enables hold count and prescaler.
    drive(0, 1, 0, 0, 14); cyc(1);
    drive(0, 0, 0, 1, 0);  cyc(1);
    chk("inc1_count", int'(count1), 15);
    cyc(3);
    chk("inc_sat_count", int'(count1), 15);
    chk("inc_sat_zero", int'(zero1), 0);
    chk("p3_inc4_count", int'(count3), 15);
    drive(0, 0, 1, 1, 0); cyc(4);
    chk("both_hold_count", int'(count1), 15);
    chk("p3_both_hold_count", int'(count3), 15);
    drive(0, 0, 1, 0, 0); cyc(1);
    chk("p3_ps_held_a", int'(count3), 15);
    chk("p1_dec_after_hold", int'(count1), 14);
    cyc(1);
    chk("p3_ps_held_b", int'(count3), 14);

    // Latch during a running down-count overrides dec.
    drive(0, 1, 0, 0, 8); cyc(1);
    drive(0, 0, 1, 0, 0); cyc(2);
    chk("pre_relatch_count", int'(count1), 6);
    drive(0, 1, 1, 0, 9); cyc(1);
    chk("relatch_count", int'(count1), 9);
    chk("relatch_expired", int'(exp1), 0);
    drive(0, 0, 1, 0, 0); cyc(1);
    chk("relatch_dec1", int'(count1), 8);
    cyc(1);
    chk("relatch_dec2", int'(count1), 7);

    // Reset when count==1 cancels the pending expiry.
    drive(0, 1, 0, 0, 3); cyc(1);
    drive(0, 0, 1, 0, 0); cyc(2);
    chk("prereset_count", int'(count1), 1);
    drive(1, 0, 1, 0, 0); cyc(1);
    chk("midreset_count", int'(count1), 0);
    chk("midreset_zero", int'(zero1), 1);
    chk("midreset_expired", int'(exp1), 0);
    chk("midreset_busy", int'(busy1), 0);

    // Up-step leaves IDLE; down-step back to 0 expires.
    drive(0, 0, 0, 1, 0); cyc(1);
    chk("idle_inc_count", int'(count1), 1);
    chk("idle_inc_busy", int'(busy1), 1);
    drive(0, 0, 1, 0, 0); cyc(1);
    chk("idle_dec_count", int'(count1), 0);
    chk("idle_dec_expired", int'(exp1), 1);
    chk("idle_dec_busy", int'(busy1), 0);

    // Latch 4 and run 8 dec cycles (auto-reload period when enabled).
    drive(0, 0, 0, 0, 0); cyc(1);
    drive(0, 1, 0, 0, 4); cyc(1);
    drive(0, 0, 1, 0, 0); cyc(3);
    chk("ar_count3", int'(count1), 1);
    cyc(1);
    chk("ar_expired4", int'(exp1), 1);
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
    chk("ar_count4", int'(count1), 4);
    chk("ar_zero4", int'(zero1), 0);
`else
    chk("ar_count4", int'(count1), 0);
    chk("ar_zero4", int'(zero1), 1);
`endif
    cyc(3);
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
    chk("ar_count7", int'(count1), 1);
`else
    chk("ar_count7", int'(count1), 0);
`endif
    cyc(1);
`ifdef LOAD_STEP_COUNTER_AUTO_RELOAD_EN
    chk("ar_expired8", int'(exp1), 1);
    chk("ar_count8", int'(count1), 4);
`else
    chk("ar_expired8", int'(exp1), 0);
    chk("ar_count8", int'(count1), 0);
`endif

    drive(0, 0, 0, 0, 0); cyc(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_step_counter.md
Name: load_step_counter

Overview:
- Parametrised successor to the team's 4-bit latch/decrement counter.
- Loadable up/down counter with programmable step prescaler, saturating limits and a run/done state machine.
- Flags `zero`, `busy` and a one-cycle `expired` pulse.
- Used as the timing/iteration counter in approximate-adder test harnesses and control paths.

Parameters:
- WIDTH, 4: counter and load-value width in bits (>=2).
- PRESCALE, 1: enabled cycles per count step (>=1); 1 = step every enabled cycle.
- PS_W, $clog2(PRESCALE+1): prescaler register width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in  in  WIDTH  load value, sampled when latch=1
- latch  in  1  load `in` into count and reload register
- dec  in  1  count-down enable
- inc  in  1  count-up enable
- count  out  WIDTH  current count (registered)
- zero  out  1  count==0 (registered with count)
- expired  out  1  one-cycle pulse when a down-step reaches 0, or a reload occurs with AUTO_RELOAD_EN
- busy  out  1  state==RUN

Behaviour:
- All state updates on the rising edge of `clock`. `reset` is synchronous, active-high and overrides everything.
- Reset values: count=0, zero=1, expired=0, busy=0, prescaler=0, reload=0, state=IDLE.
- Priority: reset > latch > step.
- Latch:
  - count<=in; reload<=in; prescaler<=0.
  - state<=RUN if in!=0, else DONE.
  - No expired pulse on latch.
  - dec/inc are ignored in the latch cycle.
- Enable:
  - Exactly one of dec/inc high: prescaler increments.
  - dec and inc both high, or both low: prescaler holds, no step.
- Step:
  - Occurs on the enabled cycle where prescaler==PRESCALE-1; prescaler then clears to 0.
  - With PRESCALE=1 every enabled cycle steps.
- Down-step:
  - count>1: count-1.
  - count==1: count<=0, state<=DONE, expired=1 for exactly that next cycle, aligned with zero first reading 1.
  - count==0: saturate; count holds, no pulse, prescaler still cycles.
- Up-step:
  - count<2^WIDTH-1: count+1; if state is DONE or IDLE, state<=RUN.
  - count==2^WIDTH-1: saturate, no wrap.
- Flag timing: `zero` and `busy` update on the same edge as count; zero latency relative to count.
- State machine:
  - IDLE: after reset. Leaves only via latch or up-step.
  - RUN: count!=0. Goes to DONE on the down-step to 0, or on latch with in==0.
  - DONE: count==0. Goes to RUN on latch with in!=0, or on an up-step.
- Reset mid-count: returns to reset values on the next edge. A pending expired pulse is cancelled.

Optional Feature:
- Macro: LOAD_STEP_COUNTER_AUTO_RELOAD_EN.
- Enabled:
  - In RUN, a down-step from count==1 with reload!=0 loads count<=reload instead of 0.
  - expired pulses one cycle; state stays RUN; zero stays 0.
  - Period is reload*PRESCALE enabled dec cycles.
  - reload==0 behaves as disabled.
- Disabled: count stops at 0 and enters DONE, as above.

Decomposition:
- Package counter_pkg:
  - state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparam helpers for all-ones/max value computation.
- Sub-module step_prescaler (params PRESCALE, PS_W):
  - Inputs: clock, reset, en, clr.
  - Output: step pulse, combinational from registered count and en.
- Top module holds the count, reload, FSM and flag logic.

Test Plan:
- WIDTH=4, PRESCALE=1. Reset, latch in=15 at cycle 2, dec=1 continuous from cycle 4 → count 15,14,…,1,0. Expected:
  - zero=1 and expired=1 on the same cycle, 15 steps after dec.
  - expired low the following cycle.
  - busy falls with zero; count holds 0 thereafter.
- PRESCALE=3, latch 5, dec=1 → count decrements every 3rd cycle; expired after 15 dec cycles. Toggling dec low for 2 cycles delays expiry by exactly 2 cycles.
- latch 14, inc=1 → 15 after 1 step, then holds 15 (no wrap to 0). dec=inc=1 for 4 cycles → count and prescaler unchanged.
- Count at 6 with dec=1; assert latch in=9 for one cycle → count=9 next cycle (dec ignored), then 8,7,… ; no expired pulse.
- Latch 3, dec=1; reset=1 at count==1 → next edge count=0, zero=1, expired=0, busy=0, state IDLE.
- With AUTO_RELOAD_EN, latch 4, dec=1 → sequence 4,3,2,1,4,3,… ; expired pulses every 4 cycles; zero never asserts.
